// File: rtl/pc_ir_unit.sv
// pc_ir_unit: PC, IR, MDR and ALUOut registers of the multicycle MIPS datapath.
// This block forms the memory address and updates the PC under the
// ControlUnit strobes. It also keeps a fetch counter and a sticky flag
// for misaligned PC writes, both for debug.
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               PCWriteCond,
    input  logic               Zero,
    input  logic               PCSource1,
    input  logic               PCSource0,
    input  logic               IorD,
    input  logic               IRWrite,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        mem_addr,
    output logic [31:0]        pc,
    output logic [31:0]        instruction,
    output logic [31:0]        mdr,
    output logic [31:0]        alu_out,
    output logic [COUNT_W-1:0] fetch_count,
    output logic               pc_misaligned
);

    logic [1:0]  pc_source;
    logic        pc_we;
    logic        pc_load;
    logic        src_valid;
    logic [31:0] pc_next;

    assign pc_source = {PCSource1, PCSource0};
    assign pc_we     = PCWrite | (PCWriteCond & Zero);
    assign pc_load   = pc_we & src_valid;

    // Memory address is a pure mux so a fetch can use the PC in the same cycle
    assign mem_addr = IorD ? alu_out : pc;

    // Select the candidate next PC; the reserved source code marks the write as void
    always_comb begin
        pc_next   = pc;
        src_valid = 1'b0;
        case (pc_source)
            2'b00: begin
                pc_next   = alu_result;
                src_valid = 1'b1;
            end
            2'b01: begin
                pc_next   = alu_out;
                src_valid = 1'b1;
            end
            2'b10: begin
                pc_next   = {pc[31:28], instruction[25:0], 2'b00};
                src_valid = 1'b1;
            end
            default: begin
                pc_next   = pc;
                src_valid = 1'b0;
            end
        endcase
    end

    // All architectural state updates together; reset wins over every strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= RESET_PC;
            instruction   <= 32'h0;
            mdr           <= 32'h0;
            alu_out       <= 32'h0;
            fetch_count   <= '0;
            pc_misaligned <= 1'b0;
        end else begin
            mdr     <= mem_rdata;
            alu_out <= alu_result;
            if (pc_load) begin
                pc <= pc_next;
                if (pc_next[1:0] != 2'b00) begin
                    pc_misaligned <= 1'b1;
                end
            end
            if (IRWrite) begin
                instruction <= mem_rdata;
                fetch_count <= fetch_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: a table of per-cycle vectors with
// hand-derived expected register values, fed through a scoreboard queue,
// followed by a counter-wrap loop and a zero-cycle address mux check.
module tb_pc_ir_unit;

    typedef struct {
        logic        rst;
        logic        pcw;
        logic        pcwc;
        logic        zero;
        logic [1:0]  src;
        logic        iord;
        logic        irw;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] epc;
        logic [31:0] eir;
        logic [31:0] emdr;
        logic [31:0] eaout;
        logic [3:0]  efc;
        logic        emis;
        logic [31:0] eaddr;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        Zero;
    logic        PCSource1;
    logic        PCSource0;
    logic        IorD;
    logic        IRWrite;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] mdr;
    logic [31:0] alu_out;
    logic [3:0]  fetch_count;
    logic        pc_misaligned;

    int   compared;
    int   mismatched;
    vec_t tbl[$];
    vec_t expQ[$];

    pc_ir_unit #(
        .RESET_PC(32'h0000_0000),
        .COUNT_W (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .Zero         (Zero),
        .PCSource1    (PCSource1),
        .PCSource0    (PCSource0),
        .IorD         (IorD),
        .IRWrite      (IRWrite),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .pc           (pc),
        .instruction  (instruction),
        .mdr          (mdr),
        .alu_out      (alu_out),
        .fetch_count  (fetch_count),
        .pc_misaligned(pc_misaligned)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rst, input logic pcw, input logic pcwc,
                                input logic zero, input logic [1:0] src, input logic iord,
                                input logic irw, input logic [31:0] alu, input logic [31:0] rdata,
                                input logic [31:0] epc, input logic [31:0] eir,
                                input logic [31:0] emdr, input logic [31:0] eaout,
                                input logic [3:0] efc, input logic emis, input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.pcw = pcw; v.pcwc = pcwc; v.zero = zero; v.src = src;
        v.iord = iord; v.irw = irw; v.alu = alu; v.rdata = rdata;
        v.epc = epc; v.eir = eir; v.emdr = emdr; v.eaout = eaout;
        v.efc = efc; v.emis = emis; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare every visible output against it
    task automatic checkOutput(input int idx);
        vec_t e;
        string tag;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: actual=0 required=1");
            return;
        end
        e = expQ.pop_front();
        tag = $sformatf("v%0d", idx);
        checkField({tag, "_pc"}, pc, e.epc);
        checkField({tag, "_instruction"}, instruction, e.eir);
        checkField({tag, "_mdr"}, mdr, e.emdr);
        checkField({tag, "_alu_out"}, alu_out, e.eaout);
        checkField({tag, "_fetch_count"}, {28'h0, fetch_count}, {28'h0, e.efc});
        checkField({tag, "_pc_misaligned"}, {31'h0, pc_misaligned}, {31'h0, e.emis});
        checkField({tag, "_mem_addr"}, mem_addr, e.eaddr);
    endtask

    // Drive one cycle's inputs at the falling edge, record the expectation, sample after the rising edge
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clock);
        reset       = v.rst;
        PCWrite     = v.pcw;
        PCWriteCond = v.pcwc;
        Zero        = v.zero;
        PCSource1   = v.src[1];
        PCSource0   = v.src[0];
        IorD        = v.iord;
        IRWrite     = v.irw;
        alu_result  = v.alu;
        mem_rdata   = v.rdata;
        expQ.push_back(v);
        @(posedge clock);
        #1;
        checkOutput(idx);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b1;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Zero        = 1'b0;
        PCSource1   = 1'b0;
        PCSource0   = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        alu_result  = 32'h0;
        mem_rdata   = 32'h0;

        // rst pcw pcwc zero src iord irw alu rdata | pc ir mdr aluout fc mis addr
        tbl.push_back(mk(1,1,0,0,2'b00,0,1,32'h123,32'hFFFFFFFF, 32'h0,32'h0,32'h0,32'h0,4'd0,0,32'h0));
        tbl.push_back(mk(1,1,0,0,2'b00,0,1,32'h123,32'hFFFFFFFF, 32'h0,32'h0,32'h0,32'h0,4'd0,0,32'h0));
        tbl.push_back(mk(0,1,0,0,2'b00,0,1,32'h4,32'h8C220004, 32'h4,32'h8C220004,32'h8C220004,32'h4,4'd1,0,32'h4));
        tbl.push_back(mk(0,0,0,0,2'b00,0,0,32'h40,32'h1111, 32'h4,32'h8C220004,32'h1111,32'h40,4'd1,0,32'h4));
        tbl.push_back(mk(0,0,1,0,2'b01,0,0,32'h40,32'h0, 32'h4,32'h8C220004,32'h0,32'h40,4'd1,0,32'h4));
        tbl.push_back(mk(0,0,1,1,2'b01,0,0,32'h80,32'h0, 32'h40,32'h8C220004,32'h0,32'h80,4'd1,0,32'h40));
        tbl.push_back(mk(0,1,1,0,2'b01,0,0,32'h90,32'h0, 32'h80,32'h8C220004,32'h0,32'h90,4'd1,0,32'h80));
        tbl.push_back(mk(0,1,0,0,2'b00,0,1,32'hA0000010,32'h08000100, 32'hA0000010,32'h08000100,32'h08000100,32'hA0000010,4'd2,0,32'hA0000010));
        tbl.push_back(mk(0,1,0,0,2'b10,0,0,32'h0,32'h0, 32'hA0000400,32'h08000100,32'h0,32'h0,4'd2,0,32'hA0000400));
        tbl.push_back(mk(0,1,0,0,2'b11,0,0,32'h3,32'h0, 32'hA0000400,32'h08000100,32'h0,32'h3,4'd2,0,32'hA0000400));
        tbl.push_back(mk(0,1,0,0,2'b00,0,0,32'h6,32'h0, 32'h6,32'h08000100,32'h0,32'h6,4'd2,1,32'h6));
        tbl.push_back(mk(0,1,0,0,2'b00,0,0,32'h8,32'h0, 32'h8,32'h08000100,32'h0,32'h8,4'd2,1,32'h8));
        tbl.push_back(mk(0,0,0,0,2'b00,1,0,32'h1234,32'h0, 32'h8,32'h08000100,32'h0,32'h1234,4'd2,1,32'h1234));
        tbl.push_back(mk(0,0,0,0,2'b00,0,0,32'h55,32'h0, 32'h8,32'h08000100,32'h0,32'h55,4'd2,1,32'h8));
        tbl.push_back(mk(1,1,0,0,2'b00,0,1,32'h77,32'hDEAD, 32'h0,32'h0,32'h0,32'h0,4'd0,0,32'h0));
        tbl.push_back(mk(0,1,0,0,2'b00,0,1,32'h4,32'hABCD, 32'h4,32'hABCD,32'hABCD,32'h4,4'd1,0,32'h4));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], i);
        end

        // Counter wrap: fifteen more fetches take the 4-bit count from 1 through 15 back to 0
        for (int i = 0; i < 15; i++) begin
            vec_t w;
            logic [3:0] fc;
            fc = 4'(2 + i);
            w = mk(0,0,0,0,2'b00,0,1,32'h100,32'(i), 32'h4,32'(i),32'(i),32'h100,fc,0,32'h4);
            applyStimulus(w, 100 + i);
        end

        // Address mux reacts without a clock edge: flip IorD mid-cycle
        @(negedge clock);
        IRWrite = 1'b0;
        IorD    = 1'b1;
        #1;
        checkField("addr_iord1_comb", mem_addr, 32'h100);
        IorD = 1'b0;
        #1;
        checkField("addr_iord0_comb", mem_addr, 32'h4);

        checkField("scoreboard_drained", 32'(expQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
# pc_ir_unit

Program-counter and instruction-holding register stage of the multicycle MIPS datapath. It sits directly upstream of `ControlUnit`. It owns PC, IR, MDR and ALUOut, and forms the memory address. It obeys `ControlUnit`'s PCWrite/PCWriteCond/PCSource/IorD/IRWrite strobes and feeds the latched `instruction` word back to `ControlUnit`. It also keeps a retired-instruction counter and a sticky PC-misalignment flag for debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- COUNT_W, 32, width of the fetch counter.

Ports:
- Clock and reset: single clock `clock`; reset `reset` is synchronous and active-high.
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- PCWrite  in  1  unconditional PC write
- PCWriteCond  in  1  PC write qualified by Zero
- Zero  in  1  ALU zero flag, same cycle as PCWriteCond
- PCSource1, PCSource0  in  1 each  PC next-value select
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  in  1  latch mem_rdata into IR
- alu_result  in  32  ALU combinational output
- mem_rdata  in  32  memory read data for current mem_addr
- mem_addr  out  32  combinational: IorD ? alu_out : pc
- pc  out  32  current PC register
- instruction  out  32  IR register, drives ControlUnit.instruction
- mdr  out  32  memory data register
- alu_out  out  32  ALUOut register
- fetch_count  out  COUNT_W  number of IRWrite cycles since reset
- pc_misaligned  out  1  sticky: a PC write with low 2 bits ≠ 00 occurred

## Operation
- PC write enable: pc_we = PCWrite | (PCWriteCond & Zero). PCWrite dominates. When both are high, the write happens regardless of Zero.
- PC next value when pc_we is high, selected by {PCSource1,PCSource0}:
  - 00: alu_result (PC+4 path).
  - 01: alu_out (branch target computed previous cycle).
  - 10: {pc[31:28], instruction[25:0], 2'b00} (jump).
  - 11: reserved. The PC holds its value and pc_misaligned is not affected.
- pc_we low: the PC holds its value.
- IR: loads mem_rdata when IRWrite=1, otherwise holds.
- MDR: loads mem_rdata every cycle, unconditionally.
- ALUOut: loads alu_result every cycle, unconditionally.
- fetch_count: increments by 1 on every cycle with IRWrite=1. It wraps from 2^COUNT_W−1 to 0 with no flag.
- pc_misaligned: set when pc_we=1, source ≠ 11, and the selected next value has [1:0] ≠ 00. The PC is still written with the unaltered value. The flag clears only on reset.
- Address arithmetic: no adders inside this block except the counter. The jump concatenation uses the current (pre-update) pc[31:28].

## Timing
- Reset (reset=1 at a clock edge): pc=RESET_PC, instruction=0, mdr=0, alu_out=0, fetch_count=0, pc_misaligned=0. Reset overrides every simultaneous strobe.
- mem_addr is combinational, zero-cycle from pc/alu_out/IorD. After reset, mem_addr=RESET_PC while IorD=0.
- Fetch cycle (IRWrite=1, PCWrite=1, PCSource=00, IorD=0):
  - IR captures mem_rdata addressed by the old PC.
  - The PC takes alu_result (PC+4) at the same edge.
  - `instruction` is valid to ControlUnit from the next cycle.
- Reset deasserted mid-sequence: the first post-reset cycle behaves as a normal cycle from reset values. No pending write survives reset.
- alu_out and mdr present the previous cycle's alu_result/mem_rdata (one-cycle latency).
- PCWriteCond with Zero=0 and PCWrite=0: no PC change and no flag change.

## Test plan
- Reset: hold reset 2 cycles with PCWrite=1, IRWrite=1, mem_rdata=32'hFFFFFFFF → pc=0, instruction=0, fetch_count=0, pc_misaligned=0, mem_addr=0.
- Fetch: pc=0, mem_rdata=32'h8C220004, alu_result=4, IRWrite=PCWrite=1, PCSource=00 → next cycle instruction=32'h8C220004, pc=4, fetch_count=1.
- Branch: alu_result=32'h40 latched into alu_out, then PCWriteCond=1, PCSource=01:
  - Zero=0 → pc unchanged.
  - Repeat with Zero=1 → pc=32'h40.
  - PCWrite=1, PCWriteCond=1, Zero=0 → pc written.
- Jump: pc=32'hA0000010, instruction=32'h08000100, PCSource=10, PCWrite=1 → pc=32'hA0000400.
- Misalignment/reserved source:
  - PCWrite=1, PCSource=00, alu_result=32'h6 → pc=6, pc_misaligned=1, and it stays 1 after a later aligned write.
  - PCSource=11 with PCWrite=1 → pc holds.
- Address mux and counter wrap:
  - IorD=1 → mem_addr=alu_out.
  - IorD=0 → mem_addr=pc.
  - With COUNT_W=4, 16 IRWrite cycles → fetch_count returns to 0.
